// File: rtl/imm_rot_encoder_pkg.sv
// Shared definitions for the rotated-immediate encoder.
// Holds the FSM state encoding and the field widths of the 12-bit shift
// operand {rotate_imm[3:0], imm8[7:0]}.
package imm_rot_encoder_pkg;

    localparam int VAL_W           = 32;
    localparam int ROT_W           = 4;
    localparam int IMM_W           = 8;
    localparam int SHIFT_OPERAND_W = ROT_W + IMM_W;  // 12
    localparam int NUM_ROT         = 1 << ROT_W;     // 16

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_RESULT = 2'd2
    } state_e;

endpackage

// File: rtl/imm_rot_check.sv
// Single-rotation test for the rotated-immediate encoder.
// Rotates value_i left by 2*rot_i. If the upper 24 bits of the result are
// zero, then value_i equals the low byte rotated right by 2*rot_i. In that
// case hit_o is high and imm8_o carries that byte.
// Ports:
//   value_i [31:0]  candidate constant
//   rot_i   [3:0]   rotation index r (rotate amount is 2*r)
//   hit_o           value_i is representable at this rotation
//   imm8_o  [7:0]   low byte of the rotated value
module imm_rot_check
    import imm_rot_encoder_pkg::*;
(
    input  logic [VAL_W-1:0] value_i,
    input  logic [ROT_W-1:0] rot_i,
    output logic             hit_o,
    output logic [IMM_W-1:0] imm8_o
);

    // Shifting the doubled word left gives a rotate-left in the upper half.
    logic [2*VAL_W-1:0] dbl;
    logic [VAL_W-1:0]   rotated;

    assign dbl     = {value_i, value_i} << {rot_i, 1'b0};
    assign rotated = dbl[2*VAL_W-1:VAL_W];
    assign hit_o   = (rotated[VAL_W-1:IMM_W] == '0);
    assign imm8_o  = rotated[IMM_W-1:0];

endmodule

// File: rtl/imm_rot_encoder.sv
// Rotated-immediate encoder. It searches for an imm8 and a rotate_imm such
// that value == imm8 ror (2*rotate_imm). The inverted value ~value is tried
// in the same pass as the MVN form. A plain hit beats an inverted hit. A
// lower rotation beats a higher one.
// Build option: IMM_ENC_FAST_EN tests all 16 rotations in one SEARCH cycle.
// Without it, the block tests one rotation per cycle, for r = 0..15.
// Ports:
//   clk, rst (sync, active-high)
//   start          request strobe; only sampled in IDLE
//   value [31:0]   constant to encode; latched on accepted start
//   busy           high in SEARCH and RESULT
//   done           one-cycle pulse in RESULT
//   encodable      an encoding was found
//   use_mvn        encoding applies to ~value
//   shift_operand  {rotate_imm[3:0], imm8[7:0]}
module imm_rot_encoder
    import imm_rot_encoder_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [VAL_W-1:0]           value,
    output logic                       busy,
    output logic                       done,
    output logic                       encodable,
    output logic                       use_mvn,
    output logic [SHIFT_OPERAND_W-1:0] shift_operand
);

    state_e                     state_q, state_d;
    logic [VAL_W-1:0]           val_q, val_d;
    logic                       enc_q, enc_d;
    logic                       mvn_q, mvn_d;
    logic [SHIFT_OPERAND_W-1:0] sop_q, sop_d;

    // Search result for the current SEARCH cycle.
    logic                       f_hit;
    logic                       f_mvn;
    logic [SHIFT_OPERAND_W-1:0] f_sop;
    logic                       f_last;  // no further rotations to try

`ifdef IMM_ENC_FAST_EN
    logic [NUM_ROT-1:0]            p_hit, n_hit;
    logic [NUM_ROT-1:0][IMM_W-1:0] p_imm, n_imm;

    for (genvar g = 0; g < NUM_ROT; g++) begin : g_rot
        imm_rot_check u_plain (
            .value_i (val_q),
            .rot_i   (ROT_W'(g)),
            .hit_o   (p_hit[g]),
            .imm8_o  (p_imm[g])
        );
        imm_rot_check u_inv (
            .value_i (~val_q),
            .rot_i   (ROT_W'(g)),
            .hit_o   (n_hit[g]),
            .imm8_o  (n_imm[g])
        );
    end

    // Scan from the highest r down, so the lowest r is written last and
    // wins. Within one r, plain is written after inverted, so plain wins.
    always_comb begin
        f_hit  = 1'b0;
        f_mvn  = 1'b0;
        f_sop  = '0;
        f_last = 1'b1;
        for (int r = NUM_ROT - 1; r >= 0; r--) begin
            if (n_hit[r]) begin
                f_hit = 1'b1;
                f_mvn = 1'b1;
                f_sop = {ROT_W'(r), n_imm[r]};
            end
            if (p_hit[r]) begin
                f_hit = 1'b1;
                f_mvn = 1'b0;
                f_sop = {ROT_W'(r), p_imm[r]};
            end
        end
    end
`else
    logic [ROT_W-1:0] cnt_q, cnt_d;
    logic             p_hit, n_hit;
    logic [IMM_W-1:0] p_imm, n_imm;

    imm_rot_check u_plain (
        .value_i (val_q),
        .rot_i   (cnt_q),
        .hit_o   (p_hit),
        .imm8_o  (p_imm)
    );
    imm_rot_check u_inv (
        .value_i (~val_q),
        .rot_i   (cnt_q),
        .hit_o   (n_hit),
        .imm8_o  (n_imm)
    );

    assign f_hit  = p_hit | n_hit;
    assign f_mvn  = ~p_hit;
    assign f_sop  = {cnt_q, p_hit ? p_imm : n_imm};
    assign f_last = &cnt_q;

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`endif

    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        enc_d   = enc_q;
        mvn_d   = mvn_q;
        sop_d   = sop_q;
`ifndef IMM_ENC_FAST_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    val_d   = value;
`ifndef IMM_ENC_FAST_EN
                    cnt_d   = '0;
`endif
                    state_d = S_SEARCH;
                end
            end
            S_SEARCH: begin
                if (f_hit) begin
                    enc_d   = 1'b1;
                    mvn_d   = f_mvn;
                    sop_d   = f_sop;
                    state_d = S_RESULT;
                end else if (f_last) begin
                    enc_d   = 1'b0;
                    mvn_d   = 1'b0;
                    sop_d   = '0;
                    state_d = S_RESULT;
                end else begin
`ifndef IMM_ENC_FAST_EN
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end
            S_RESULT: state_d = S_IDLE;  // start is ignored here
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            val_q   <= '0;
            enc_q   <= 1'b0;
            mvn_q   <= 1'b0;
            sop_q   <= '0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            enc_q   <= enc_d;
            mvn_q   <= mvn_d;
            sop_q   <= sop_d;
        end
    end

    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_RESULT);
    assign encodable     = enc_q;
    assign use_mvn       = mvn_q;
    assign shift_operand = sop_q;

endmodule

// File: doc/imm_rot_encoder.md
IMM_ROT_ENCODER -- requirements
Module: imm_rot_encoder

Interface
REQ-001 Parameters SHALL be none; all widths are fixed (32-bit value, 12-bit shift operand).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request strobe; sampled only in IDLE.
REQ-005 value  input  32  constant to encode; latched when start is accepted.
REQ-006 busy  output  1  high while a search is in progress.
REQ-007 done  output  1  one-cycle pulse marking valid results.
REQ-008 encodable  output  1  a rotated-immediate encoding was found.
REQ-009 use_mvn  output  1  the encoding is for ~value (MVN/inverted form), not value.
REQ-010 shift_operand  output  12  {rotate_imm[3:0], imm8[7:0]}; the decode is imm8 rotated right by 2*rotate_imm.

Function
REQ-011 The FSM SHALL have states IDLE, SEARCH, RESULT.
REQ-012 IDLE with start=1 at cycle T SHALL latch value, clear the rotation counter to 0, and enter SEARCH at T+1.
REQ-013 SEARCH SHALL test one rotation r per cycle: r=0 at T+1 through r=15 at T+16; counter width 4 bits.
REQ-014 The test at r SHALL compute R = value rotated left by 2*r; a plain hit requires R[31:24..8] all zero (R[31:8]==0).
REQ-015 The same cycle SHALL test ~value the same way (inverted hit).
REQ-016 On a hit, a plain hit SHALL win over an inverted hit at the same r, and a lower r SHALL win over a higher r.
REQ-017 On a hit at r, the block SHALL record encodable=1, use_mvn, rotate_imm=r, imm8=R[7:0], and enter RESULT.
REQ-018 If r=15 misses, the block SHALL record encodable=0, use_mvn=0, shift_operand=0, and enter RESULT.
REQ-019 RESULT SHALL assert done for exactly one cycle (T+2+r, or T+17 on total miss) and return to IDLE.
REQ-020 busy SHALL be 1 in SEARCH and RESULT, and 0 in IDLE.
REQ-021 start SHALL be ignored while busy=1, and the latched value SHALL NOT change.
REQ-022 encodable, use_mvn and shift_operand SHALL hold their last values until the next RESULT.
REQ-023 A start in the same cycle as the done pulse SHALL be ignored; start is accepted from the following IDLE cycle.

Reset
REQ-024 rst=1 SHALL force IDLE, busy=0, done=0, encodable=0, use_mvn=0, shift_operand=0, and counter=0, regardless of state.
REQ-025 rst asserted mid-SEARCH SHALL abort the search with no done pulse; start is accepted in the first cycle after rst deasserts.

Configuration
REQ-026 With IMM_ENC_FAST_EN defined, SEARCH SHALL evaluate all 16 rotations (plain and inverted) in parallel in one cycle, with the priority rule unchanged; done SHALL occur at T+2 always.
REQ-027 Without IMM_ENC_FAST_EN, the iterative one-rotation-per-cycle behaviour of REQ-013..REQ-019 SHALL apply.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding, the 4-bit rotate width, the 8-bit imm width, and the SHIFT_OPERAND_W=12 constant.
REQ-029 One sub-module, imm_rot_check, SHALL implement a single-rotation test (value, r -> hit, imm8); it is instantiated once (iterative) or as 16 copies x 2 (fast).

Verification
REQ-030 value=0x000000FF, start at T -> done at T+2, encodable=1, use_mvn=0, shift_operand=0x0FF.
REQ-031 value=0xFF000000 -> done at T+6, shift_operand=0x4FF, use_mvn=0.
REQ-032 value=0x00000104 -> done at T+17, shift_operand=0xF41; value=0xFFFFFFFF -> done at T+2, use_mvn=1, shift_operand=0x000.
REQ-033 value=0x00000101 -> done at T+17, encodable=0, shift_operand=0x000; a start pulsed at T+5 is ignored.
REQ-034 rst pulsed at T+4 during value=0x00000104 -> no done pulse, all outputs 0; a new start at T+6 completes normally.
REQ-035 Rerun REQ-030..REQ-033 with IMM_ENC_FAST_EN -> identical results, each done at T+2.
